// File: rtl/cart_bus_pkg.sv
// cart_bus_pkg: shared types and defaults for the cartridge bus host.
package cart_bus_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ADDR_W = 23;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_e;
  typedef struct packed {
    logic              we;
    logic              chr;
    logic              wram;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } mem_req_t;
endpackage

// File: rtl/map_bus.sv
// map_bus: signal bundle between the cart bus host and the active mapper.
interface map_bus #(parameter int ADDR_BITS = 23);
  logic                 reset, m2, cpu_rw, ppu_rd, ppu_wr;
  logic [15:0]          cpu_addr;
  logic [7:0]           cpu_data_in, cpu_data_out;
  logic [13:0]          ppu_addr;
  logic                 prg_oe, prg_we, wram_ce, chr_oe, chr_we, chr_ce, chr_ram, custom_cpu_out, irq;
  logic [ADDR_BITS-1:0] prg_addr, chr_addr;
  modport host (
    output reset, m2, cpu_addr, cpu_data_in, cpu_rw, ppu_rd, ppu_wr, ppu_addr,
    input  prg_oe, prg_we, wram_ce, chr_oe, chr_we, chr_ce, chr_ram, custom_cpu_out, irq,
           prg_addr, chr_addr, cpu_data_out
  );
  modport mapper (
    input  reset, m2, cpu_addr, cpu_data_in, cpu_rw, ppu_rd, ppu_wr, ppu_addr,
    output prg_oe, prg_we, wram_ce, chr_oe, chr_we, chr_ce, chr_ram, custom_cpu_out, irq,
           prg_addr, chr_addr, cpu_data_out
  );
endinterface

// File: rtl/cart_sync.sv
// cart_sync: multi-stage synchronizer with rise/fall pulses on the synchronized value.
module cart_sync #(
  parameter int           W      = 1,
  parameter int           STAGES = 2,
  parameter logic [W-1:0] RST    = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [STAGES-1:0][W-1:0] s_q, s_d;
  logic [W-1:0]             p_q, p_d;
  always_comb begin
    s_d = {s_q[STAGES-2:0], d};
    p_d = s_q[STAGES-1];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s_q <= {STAGES{RST}};
      p_q <= RST;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  assign q    = s_q[STAGES-1];
  assign rise = q & ~p_q;
  assign fall = ~q & p_q;
endmodule

// File: rtl/cart_bus_host.sv
// cart_bus_host: samples the cart edge, feeds the mapper and turns its strobes
// into single-shot requests on a byte-wide memory port (CHR before PRG).
module cart_bus_host
  import cart_bus_pkg::*;
#(
  parameter int ADDR_BITS   = ADDR_W,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cart_m2,
  input  logic [15:0]          cart_cpu_addr,
  input  logic                 cart_cpu_rw,
  input  logic [7:0]           cart_cpu_data_in,
  output logic [7:0]           cart_cpu_data_out,
  output logic                 cart_cpu_data_oe,
  input  logic                 cart_ppu_rd_n,
  input  logic                 cart_ppu_wr_n,
  input  logic [13:0]          cart_ppu_addr,
  input  logic [7:0]           cart_ppu_data_in,
  output logic [7:0]           cart_ppu_data_out,
  output logic                 cart_ppu_data_oe,
  output logic                 cart_irq_n,
  map_bus.host                 bus,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_chr,
  output logic                 mem_wram,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata
);
  logic        m2_s, rd_n_s, wr_n_s, m2_rise, m2_fall, rd_rise, rd_fall, wr_fall, wr_rise_unused;
  logic [15:0] cpu_addr_s;
  logic        cpu_rw_s;
  logic [7:0]  cpu_din_s, ppu_din_s;
  logic [13:0] ppu_addr_s;
  logic [46:0] bus_rise_unused, bus_fall_unused;
  cart_sync #(.W(3), .STAGES(SYNC_STAGES), .RST(3'b011)) u_strb (
    .clk, .reset_n, .d({cart_m2, cart_ppu_rd_n, cart_ppu_wr_n}), .q({m2_s, rd_n_s, wr_n_s}),
    .rise({m2_rise, rd_rise, wr_rise_unused}), .fall({m2_fall, rd_fall, wr_fall})
  );
  cart_sync #(.W(47), .STAGES(SYNC_STAGES), .RST({16'h0, 1'b1, 30'h0})) u_bus (
    .clk, .reset_n,
    .d({cart_cpu_addr, cart_cpu_rw, cart_cpu_data_in, cart_ppu_addr, cart_ppu_data_in}),
    .q({cpu_addr_s, cpu_rw_s, cpu_din_s, ppu_addr_s, ppu_din_s}),
    .rise(bus_rise_unused), .fall(bus_fall_unused)
  );
  arb_state_e  state_q, state_d;
  mem_req_t    req_q, req_d, chr_slot_q, chr_slot_d, prg_slot_q, prg_slot_d;
  logic        mem_req_q, mem_req_d, chr_pend_q, chr_pend_d, prg_pend_q, prg_pend_d;
  logic        overrun_q, overrun_d, bus_reset_q, bus_reset_d, irq_n_q, irq_n_d;
  logic [15:0] cpu_addr_q, cpu_addr_d;
  logic        cpu_rw_q, cpu_rw_d;
  logic [7:0]  cpu_din_q, cpu_din_d, ppu_din_q, ppu_din_d;
  logic [13:0] ppu_addr_q, ppu_addr_d;
  logic        rd_chk_q, rd_chk_d, wr_chk_q, wr_chk_d, crd_chk_q, crd_chk_d, cwr_chk_q, cwr_chk_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d, ppu_dout_q, ppu_dout_d;
  logic        cpu_oe_q, cpu_oe_d, ppu_oe_q, ppu_oe_d, chr_post, prg_post;
  always_comb begin
    bus_reset_d = 1'b0;
    irq_n_d     = ~bus.irq;
    cpu_addr_d  = m2_rise ? cpu_addr_s : cpu_addr_q;
    cpu_rw_d    = m2_rise ? cpu_rw_s : cpu_rw_q;
    rd_chk_d    = m2_rise & cpu_rw_s;
    cpu_din_d   = m2_fall ? cpu_din_s : cpu_din_q;
    wr_chk_d    = m2_fall & ~cpu_rw_q;
    ppu_addr_d  = (rd_fall | wr_fall) ? ppu_addr_s : ppu_addr_q;
    ppu_din_d   = wr_fall ? ppu_din_s : ppu_din_q;
    crd_chk_d   = rd_fall;
    cwr_chk_d   = wr_fall;
    cpu_dout_d  = cpu_dout_q;
    cpu_oe_d    = cpu_oe_q & ~m2_fall;
    ppu_dout_d  = ppu_dout_q;
    ppu_oe_d    = ppu_oe_q & ~rd_rise;
    chr_pend_d  = chr_pend_q & ~(state_q == DONE && req_q.chr);
    prg_pend_d  = prg_pend_q & ~(state_q == DONE && !req_q.chr);
    chr_slot_d  = chr_slot_q;
    prg_slot_d  = prg_slot_q;
    overrun_d   = overrun_q;
    state_d     = state_q;
    req_d       = req_q;
    // The mapper has had one cycle to decode the freshly latched cycle.
    chr_post = (crd_chk_q & bus.chr_oe & bus.chr_ce) | (cwr_chk_q & bus.chr_we & bus.chr_ram);
    prg_post = (rd_chk_q & bus.prg_oe & ~bus.custom_cpu_out) | (wr_chk_q & bus.prg_we);
    if (chr_post) begin
      overrun_d  = overrun_d | chr_pend_d;
      chr_pend_d = 1'b1;
      chr_slot_d = '{we: cwr_chk_q, chr: 1'b1, wram: 1'b0, addr: ADDR_W'(bus.chr_addr), wdata: ppu_din_q};
    end
    if (prg_post) begin
      overrun_d  = overrun_d | prg_pend_d;
      prg_pend_d = 1'b1;
      prg_slot_d = '{we: wr_chk_q, chr: 1'b0, wram: bus.wram_ce, addr: ADDR_W'(bus.prg_addr), wdata: cpu_din_q};
    end
    if (rd_chk_q && bus.custom_cpu_out) begin
      cpu_dout_d = bus.cpu_data_out;
      cpu_oe_d   = m2_s;
    end
    if (state_q == IDLE && (chr_pend_d || prg_pend_d)) begin
      state_d = ISSUE;
      req_d   = chr_pend_d ? chr_slot_d : prg_slot_d;
    end else if (state_q == ISSUE && mem_ack) begin
      state_d = DONE;
      // Read data is dropped if the requesting strobe has already gone away.
      if (!req_q.we && !req_q.chr && m2_s && cpu_rw_q) begin
        cpu_dout_d = mem_rdata;
        cpu_oe_d   = 1'b1;
      end
      if (!req_q.we && req_q.chr && !rd_n_s) begin
        ppu_dout_d = mem_rdata;
        ppu_oe_d   = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    mem_req_d = state_d == ISSUE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      chr_slot_q  <= '0;
      prg_slot_q  <= '0;
      mem_req_q   <= 1'b0;
      chr_pend_q  <= 1'b0;
      prg_pend_q  <= 1'b0;
      overrun_q   <= 1'b0;
      bus_reset_q <= 1'b1;
      irq_n_q     <= 1'b1;
      cpu_addr_q  <= '0;
      cpu_rw_q    <= 1'b1;
      cpu_din_q   <= '0;
      ppu_addr_q  <= '0;
      ppu_din_q   <= '0;
      rd_chk_q    <= 1'b0;
      wr_chk_q    <= 1'b0;
      crd_chk_q   <= 1'b0;
      cwr_chk_q   <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_oe_q    <= 1'b0;
      ppu_dout_q  <= '0;
      ppu_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      chr_slot_q  <= chr_slot_d;
      prg_slot_q  <= prg_slot_d;
      mem_req_q   <= mem_req_d;
      chr_pend_q  <= chr_pend_d;
      prg_pend_q  <= prg_pend_d;
      overrun_q   <= overrun_d;
      bus_reset_q <= bus_reset_d;
      irq_n_q     <= irq_n_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_rw_q    <= cpu_rw_d;
      cpu_din_q   <= cpu_din_d;
      ppu_addr_q  <= ppu_addr_d;
      ppu_din_q   <= ppu_din_d;
      rd_chk_q    <= rd_chk_d;
      wr_chk_q    <= wr_chk_d;
      crd_chk_q   <= crd_chk_d;
      cwr_chk_q   <= cwr_chk_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_oe_q    <= cpu_oe_d;
      ppu_dout_q  <= ppu_dout_d;
      ppu_oe_q    <= ppu_oe_d;
    end
  assign bus.reset         = bus_reset_q;
  assign bus.m2            = m2_s;
  assign bus.ppu_rd        = ~rd_n_s;
  assign bus.ppu_wr        = ~wr_n_s;
  assign bus.cpu_addr      = cpu_addr_q;
  assign bus.cpu_rw        = cpu_rw_q;
  assign bus.cpu_data_in   = cpu_din_q;
  assign bus.ppu_addr      = ppu_addr_q;
  assign mem_req           = mem_req_q;
  assign mem_we            = req_q.we;
  assign mem_chr           = req_q.chr;
  assign mem_wram          = req_q.wram;
  assign mem_addr          = ADDR_BITS'(req_q.addr);
  assign mem_wdata         = req_q.wdata;
  assign cart_cpu_data_out = cpu_dout_q;
  assign cart_cpu_data_oe  = cpu_oe_q;
  assign cart_ppu_data_out = ppu_dout_q;
  assign cart_ppu_data_oe  = ppu_oe_q;
  assign cart_irq_n        = irq_n_q;
endmodule

// File: tb/tb_cart_bus_host.sv
// tb_cart_bus_host: directed checks of the cart bus host with a stub mapper and memory.
module tb_cart_bus_host;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cart_m2 = 1'b0, cart_cpu_rw = 1'b1, cart_ppu_rd_n = 1'b1, cart_ppu_wr_n = 1'b1;
  logic [15:0] cart_cpu_addr = '0;
  logic [7:0]  cart_cpu_data_in = '0, cart_ppu_data_in = '0, mem_rdata = '0;
  logic [13:0] cart_ppu_addr = '0;
  logic [7:0]  cart_cpu_data_out, cart_ppu_data_out, mem_wdata;
  logic        cart_cpu_data_oe, cart_ppu_data_oe, cart_irq_n;
  logic        mem_req, mem_we, mem_chr, mem_wram, mem_ack = 1'b0;
  logic [22:0] mem_addr;
  int          checks = 0, failures = 0, req_rises = 0, base;
  logic        req_prev = 1'b0;
  map_bus #(.ADDR_BITS(23)) b ();
  cart_bus_host #(.ADDR_BITS(23), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cart_m2(cart_m2), .cart_cpu_addr(cart_cpu_addr),
    .cart_cpu_rw(cart_cpu_rw), .cart_cpu_data_in(cart_cpu_data_in),
    .cart_cpu_data_out(cart_cpu_data_out), .cart_cpu_data_oe(cart_cpu_data_oe),
    .cart_ppu_rd_n(cart_ppu_rd_n), .cart_ppu_wr_n(cart_ppu_wr_n), .cart_ppu_addr(cart_ppu_addr),
    .cart_ppu_data_in(cart_ppu_data_in), .cart_ppu_data_out(cart_ppu_data_out),
    .cart_ppu_data_oe(cart_ppu_data_oe), .cart_irq_n(cart_irq_n), .bus(b),
    .mem_req(mem_req), .mem_we(mem_we), .mem_chr(mem_chr), .mem_wram(mem_wram),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_req && !req_prev) req_rises++;
    req_prev = mem_req;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic serve(input int lat, input logic [7:0] rd);
    int n = 0;
    while (mem_req !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("serve_req_seen", {31'b0, mem_req}, 1);
    repeat (lat) step();
    mem_ack = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack = 1'b0;
  endtask
  initial begin
    {b.prg_oe, b.prg_we, b.wram_ce, b.chr_oe, b.chr_we, b.chr_ce, b.chr_ram, b.custom_cpu_out, b.irq} = '0;
    b.prg_addr = '0;
    b.chr_addr = '0;
    b.cpu_data_out = '0;
    repeat (2) step();
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_fields", {mem_we, mem_chr, mem_wram, mem_addr, mem_wdata}, 0);
    chk("rst_pads", {cart_cpu_data_oe, cart_ppu_data_oe, cart_cpu_data_out, cart_ppu_data_out}, 0);
    chk("rst_irq_n", {31'b0, cart_irq_n}, 1);
    chk("rst_bus", {b.reset, b.m2, b.ppu_rd, b.ppu_wr, b.cpu_rw}, 5'b10001);
    reset_n = 1'b1;
    step();
    chk("bus_reset_release", {31'b0, b.reset}, 0);
    b.irq = 1'b1;
    step();
    chk("irq_assert", {31'b0, cart_irq_n}, 0);
    b.irq = 1'b0;
    step();
    chk("irq_release", {31'b0, cart_irq_n}, 1);
    // CPU read
    b.prg_oe = 1'b1;
    b.prg_addr = 23'h0;
    base = req_rises;
    cart_cpu_addr = 16'h8000;
    cart_cpu_rw = 1'b1;
    cart_m2 = 1'b1;
    repeat (3) step();
    chk("rd_latency_early", {31'b0, mem_req}, 0);
    chk("rd_bus_addr", {16'b0, b.cpu_addr}, 32'h8000);
    step();
    chk("rd_latency", {31'b0, mem_req}, 1);
    chk("rd_fields", {mem_we, mem_chr, mem_addr}, 0);
    serve(2, 8'hA9);
    chk("rd_req_drop", {31'b0, mem_req}, 0);
    chk("rd_data", {24'b0, cart_cpu_data_out}, 32'hA9);
    chk("rd_oe", {31'b0, cart_cpu_data_oe}, 1);
    repeat (3) step();
    chk("rd_single_req", req_rises - base, 1);
    cart_m2 = 1'b0;
    repeat (2) step();
    chk("rd_oe_hold", {31'b0, cart_cpu_data_oe}, 1);
    step();
    chk("rd_oe_clear", {31'b0, cart_cpu_data_oe}, 0);
    // CPU write
    b.prg_oe = 1'b0;
    b.prg_we = 1'b1;
    b.wram_ce = 1'b1;
    b.prg_addr = 23'h1000;
    cart_cpu_addr = 16'h6000;
    cart_cpu_rw = 1'b0;
    cart_cpu_data_in = 8'h55;
    cart_m2 = 1'b1;
    repeat (6) step();
    chk("wr_no_req_m2_high", {31'b0, mem_req}, 0);
    cart_m2 = 1'b0;
    repeat (3) step();
    chk("wr_latency_early", {31'b0, mem_req}, 0);
    chk("wr_bus_data", {24'b0, b.cpu_data_in}, 32'h55);
    step();
    chk("wr_req", {mem_req, mem_we, mem_chr, mem_wram}, 4'b1101);
    chk("wr_addr_data", {mem_addr, mem_wdata}, {23'h1000, 8'h55});
    serve(1, 8'h00);
    chk("wr_done", {31'b0, mem_req}, 0);
    b.prg_we = 1'b0;
    b.wram_ce = 1'b0;
    cart_cpu_rw = 1'b1;
    repeat (3) step();
    // Collision: CHR read and PRG read post together
    b.prg_oe = 1'b1;
    b.prg_addr = 23'h42;
    b.chr_oe = 1'b1;
    b.chr_ce = 1'b1;
    b.chr_addr = 23'h1234;
    base = req_rises;
    cart_cpu_addr = 16'h8042;
    cart_ppu_addr = 14'h1234;
    cart_m2 = 1'b1;
    cart_ppu_rd_n = 1'b0;
    repeat (4) step();
    chk("col_chr_first", {mem_req, mem_chr, mem_we}, 3'b110);
    chk("col_chr_addr", {9'b0, mem_addr}, 32'h1234);
    chk("col_bus_ppu_addr", {18'b0, b.ppu_addr}, 32'h1234);
    serve(0, 8'h5A);
    chk("col_ppu_data", {cart_ppu_data_oe, cart_ppu_data_out}, {1'b1, 8'h5A});
    step();
    chk("col_done_gap", {31'b0, mem_req}, 0);
    step();
    chk("col_prg_next", {mem_req, mem_chr, mem_addr}, {2'b10, 23'h42});
    serve(1, 8'h77);
    chk("col_cpu_data", {cart_cpu_data_oe, cart_cpu_data_out}, {1'b1, 8'h77});
    chk("col_two_reqs", req_rises - base, 2);
    cart_m2 = 1'b0;
    cart_ppu_rd_n = 1'b1;
    b.chr_oe = 1'b0;
    repeat (3) step();
    chk("col_oe_clear", {cart_cpu_data_oe, cart_ppu_data_oe}, 0);
    // Custom CPU output
    b.custom_cpu_out = 1'b1;
    b.cpu_data_out = 8'h3C;
    base = req_rises;
    cart_m2 = 1'b1;
    repeat (4) step();
    chk("cust_pads", {cart_cpu_data_oe, cart_cpu_data_out}, {1'b1, 8'h3C});
    repeat (4) step();
    chk("cust_no_req", req_rises - base, 0);
    cart_m2 = 1'b0;
    b.custom_cpu_out = 1'b0;
    repeat (4) step();
    chk("cust_oe_clear", {31'b0, cart_cpu_data_oe}, 0);
    // Read whose strobe ends before the ack: completes, data discarded
    cart_m2 = 1'b1;
    repeat (4) step();
    chk("disc_req", {31'b0, mem_req}, 1);
    cart_m2 = 1'b0;
    repeat (3) step();
    serve(0, 8'hEE);
    chk("disc_completed", {31'b0, mem_req}, 0);
    chk("disc_pads", {cart_cpu_data_oe, cart_cpu_data_out}, {1'b0, 8'h3C});
    // CHR write gating
    b.prg_oe = 1'b0;
    b.chr_we = 1'b1;
    b.chr_ram = 1'b0;
    b.chr_addr = 23'h155;
    cart_ppu_addr = 14'h155;
    cart_ppu_data_in = 8'h99;
    base = req_rises;
    cart_ppu_wr_n = 1'b0;
    repeat (6) step();
    chk("cwr_gated", req_rises - base, 0);
    cart_ppu_wr_n = 1'b1;
    repeat (4) step();
    b.chr_ram = 1'b1;
    cart_ppu_wr_n = 1'b0;
    repeat (4) step();
    chk("cwr_req", {mem_req, mem_we, mem_chr, mem_wram}, 4'b1110);
    chk("cwr_fields", {mem_addr, mem_wdata}, {23'h155, 8'h99});
    serve(0, 8'h00);
    chk("cwr_one_req", req_rises - base, 1);
    cart_ppu_wr_n = 1'b1;
    b.chr_we = 1'b0;
    repeat (4) step();
    // Reset while a request is outstanding
    b.prg_oe = 1'b1;
    b.prg_addr = 23'h200;
    cart_m2 = 1'b1;
    repeat (4) step();
    chk("mrst_issue", {31'b0, mem_req}, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_req_drop", {31'b0, mem_req}, 0);
    chk("mrst_mem_fields", {mem_we, mem_chr, mem_wram, mem_addr, mem_wdata}, 0);
    chk("mrst_pads", {cart_cpu_data_oe, cart_ppu_data_oe, cart_cpu_data_out, cart_ppu_data_out, cart_irq_n}, 1);
    chk("mrst_bus", {b.reset, b.m2, b.ppu_rd, b.ppu_wr, b.cpu_rw}, 5'b10001);
    cart_m2 = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (2) step();
    cart_m2 = 1'b1;
    repeat (4) step();
    chk("mrst_resume_req", {mem_req, mem_chr, mem_addr}, {2'b10, 23'h200});
    serve(1, 8'h31);
    chk("mrst_resume_data", {cart_cpu_data_oe, cart_cpu_data_out}, {1'b1, 8'h31});
    cart_m2 = 1'b0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
